// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register sequencer for the multi-cycle divider
// and multiplier, plus the mthi/mtlo direct-write path.
module hilo_ctrl #(
  parameter int CNT_WIDTH        = 16,
  parameter bit DIV0_WRITES_HILO = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_div,
  input  logic                 start_mult,
  input  logic                 mthi,
  input  logic                 mtlo,
  input  logic [31:0]          wr_data,
  output logic                 div_ctrl,
  input  logic                 div_done,
  input  logic                 div0,
  input  logic [31:0]          div_hi,
  input  logic [31:0]          div_lo,
  output logic                 mult_ctrl,
  input  logic                 mult_done,
  input  logic [31:0]          mult_hi,
  input  logic [31:0]          mult_lo,
  output logic [31:0]          hi,
  output logic [31:0]          lo,
  output logic                 busy,
  output logic                 op_done,
  output logic                 div0_exc,
  output logic                 start_conflict,
  output logic [CNT_WIDTH-1:0] busy_cycles
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] MULT_RUN = 2'd2;
  localparam logic [1:0] CAPTURE  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic        first;
  logic [31:0] hold_hi;
  logic [31:0] hold_lo;
  logic        hold_div0;
  logic        div_cap;
  logic        mult_cap;
  logic        launch;
  logic        hilo_wr;

  // done is only trusted from the second RUN cycle on (stale-done guard)
  assign div_cap  = (state == DIV_RUN) && !first && div_done;
  assign mult_cap = (state == MULT_RUN) && !first && mult_done;
  assign launch   = (state == IDLE) && (start_div || start_mult);
  assign hilo_wr  = (state == CAPTURE) &&
                    (!hold_div0 || DIV0_WRITES_HILO);

  // next-state selection; divide wins a simultaneous request
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start_div)
          state_n = DIV_RUN;
        else if (start_mult)
          state_n = MULT_RUN;
      end
      DIV_RUN: begin
        if (div_cap)
          state_n = CAPTURE;
      end
      MULT_RUN: begin
        if (mult_cap)
          state_n = CAPTURE;
      end
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state, first-cycle flag and registered control/pulse outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      first          <= 1'b0;
      div_ctrl       <= 1'b0;
      mult_ctrl      <= 1'b0;
      busy           <= 1'b0;
      op_done        <= 1'b0;
      div0_exc       <= 1'b0;
      start_conflict <= 1'b0;
    end else begin
      state          <= state_n;
      first          <= launch;
      div_ctrl       <= (state_n == DIV_RUN);
      mult_ctrl      <= (state_n == MULT_RUN);
      busy           <= (state_n != IDLE);
      op_done        <= div_cap || mult_cap;
      div0_exc       <= div_cap && div0;
      start_conflict <= (state == IDLE) &&
                        start_div && start_mult;
    end
  end

  // holding registers latch the unit result on its done
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_hi   <= 32'h0;
      hold_lo   <= 32'h0;
      hold_div0 <= 1'b0;
    end else if (div_cap) begin
      hold_hi   <= div_hi;
      hold_lo   <= div_lo;
      hold_div0 <= div0;
    end else if (mult_cap) begin
      hold_hi   <= mult_hi;
      hold_lo   <= mult_lo;
      hold_div0 <= 1'b0;
    end
  end

  // architectural HI/LO: result commit in CAPTURE, mthi/mtlo in IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= 32'h0;
      lo <= 32'h0;
    end else if (hilo_wr) begin
      hi <= hold_hi;
      lo <= hold_lo;
    end else if (state == IDLE) begin
      if (mthi)
        hi <= wr_data;
      if (mtlo)
        lo <= wr_data;
    end
  end

  // busy-cycle counter: cleared at launch, saturating, held in IDLE
  always_ff @(posedge clock) begin
    if (reset)
      busy_cycles <= '0;
    else if (launch)
      busy_cycles <= '0;
    else if (state != IDLE && busy_cycles != '1)
      busy_cycles <= busy_cycles + CNT_ONE;
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed sequence with a result scoreboard
// for hilo_ctrl.
module tb_hilo_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_div, start_mult, mthi, mtlo;
  logic [31:0] wr_data;
  logic        div_ctrl, div_done, div0;
  logic [31:0] div_hi, div_lo;
  logic        mult_ctrl, mult_done;
  logic [31:0] mult_hi, mult_lo;
  logic [31:0] hi, lo;
  logic        busy, op_done, div0_exc, start_conflict;
  logic [15:0] busy_cycles;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        exc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  always #5 clock = ~clock;

  hilo_ctrl dut (
    .clock(clock), .reset(reset),
    .start_div(start_div), .start_mult(start_mult),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
    .div_ctrl(div_ctrl), .div_done(div_done), .div0(div0),
    .div_hi(div_hi), .div_lo(div_lo),
    .mult_ctrl(mult_ctrl), .mult_done(mult_done),
    .mult_hi(mult_hi), .mult_lo(mult_lo),
    .hi(hi), .lo(lo), .busy(busy), .op_done(op_done),
    .div0_exc(div0_exc), .start_conflict(start_conflict),
    .busy_cycles(busy_cycles)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] h,
                      input logic [31:0] l,
                      input logic e);
    exp_t x;
    x.hi  = h;
    x.lo  = l;
    x.exc = e;
    q.push_back(x);
  endtask

  // wait (bounded) for op_done, then score the committed result
  task automatic finish_op(input string tag);
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      if (op_done === 1'b1)
        break;
      tick();
    end
    chk({tag, "_op_done"}, op_done, 1);
    if (q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_exc"}, div0_exc, e.exc);
    chk({tag, "_ctrl_cap"}, {div_ctrl, mult_ctrl}, 0);
    chk({tag, "_busy_cap"}, busy, 1);
    tick();
    chk({tag, "_hi"}, hi, e.hi);
    chk({tag, "_lo"}, lo, e.lo);
    chk({tag, "_done_pulse"}, op_done, 0);
    chk({tag, "_exc_pulse"}, div0_exc, 0);
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    start_div = 0; start_mult = 0; mthi = 0; mtlo = 0;
    wr_data = 0; div_done = 0; div0 = 0;
    div_hi = 0; div_lo = 0;
    mult_done = 0; mult_hi = 0; mult_lo = 0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl", {div_ctrl, mult_ctrl}, 0);
    chk("rst_pulses", {op_done, div0_exc, start_conflict}, 0);
    chk("rst_cnt", busy_cycles, 0);

    // mthi in IDLE
    mthi = 1; wr_data = 32'h12345678;
    tick();
    mthi = 0;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, 0);

    // divide 7 / -3
    start_div = 1;
    tick();
    start_div = 0;
    chk("div_ctrl_up", div_ctrl, 1);
    chk("div_mult_low", mult_ctrl, 0);
    chk("div_busy", busy, 1);
    push(32'h00000001, 32'hFFFFFFFE, 0);
    div_hi = 32'h00000001; div_lo = 32'hFFFFFFFE;
    tick(); tick(); tick();
    chk("div_run_ctrl", div_ctrl, 1);
    div_done = 1;
    tick();
    div_done = 0;
    finish_op("div73");
    chk("div73_ctrl_after", div_ctrl, 0);
    chk("div73_cnt", busy_cycles, 5);

    // divide by zero, HI/LO must be preserved
    mthi = 1; wr_data = 32'hAAAA0000;
    tick();
    mthi = 0;
    start_div = 1;
    tick();
    start_div = 0;
    tick();
    div_done = 1; div0 = 1;
    div_hi = 32'h0BAD0BAD; div_lo = 32'h0BAD0BAD;
    push(32'hAAAA0000, 32'hFFFFFFFE, 1);
    tick();
    div_done = 0; div0 = 0;
    finish_op("div0");
    chk("div0_cnt", busy_cycles, 3);

    // simultaneous start: divide wins, conflict pulse
    start_div = 1; start_mult = 1;
    tick();
    start_div = 0;
    chk("conf_pulse", start_conflict, 1);
    chk("conf_div", div_ctrl, 1);
    chk("conf_mult", mult_ctrl, 0);
    // start_mult still held while busy: ignored
    tick();
    start_mult = 0;
    chk("conf_pulse_end", start_conflict, 0);
    chk("busy_start_ign", mult_ctrl, 0);
    div_hi = 32'h5; div_lo = 32'h6; div_done = 1;
    push(32'h5, 32'h6, 0);
    tick();
    div_done = 0;
    finish_op("conf");

    // multiply with mtlo during MULT_RUN ignored
    start_mult = 1;
    tick();
    start_mult = 0;
    chk("mul_ctrl", {div_ctrl, mult_ctrl}, 2'b01);
    mtlo = 1; wr_data = 32'hDEADBEEF;
    tick();
    mtlo = 0;
    chk("mul_mtlo_ign", lo, 32'h6);
    mult_hi = 32'h11111111; mult_lo = 32'h22222222;
    mult_done = 1;
    push(32'h11111111, 32'h22222222, 0);
    tick();
    mult_done = 0;
    finish_op("mul");

    // stale div_done already high at launch
    div_done = 1;
    div_hi = 32'hBADBAD00; div_lo = 32'hBADBAD01;
    start_div = 1;
    tick();
    start_div = 0;
    tick();
    div_done = 0;
    chk("stale_no_done", op_done, 0);
    chk("stale_busy", busy, 1);
    tick();
    div_hi = 32'h33333333; div_lo = 32'h44444444;
    div_done = 1;
    push(32'h33333333, 32'h44444444, 0);
    tick();
    div_done = 0;
    finish_op("stale");

    // back-to-back start right after CAPTURE
    start_mult = 1;
    tick();
    start_mult = 0;
    chk("b2b_mult", mult_ctrl, 1);
    mult_done = 1;
    mult_hi = 32'h55555555; mult_lo = 32'h66666666;
    tick();
    push(32'h55555555, 32'h66666666, 0);
    tick();
    mult_done = 0;
    finish_op("b2b");

    // mthi and mtlo together
    mthi = 1; mtlo = 1; wr_data = 32'h0F0F0F0F;
    tick();
    mthi = 0; mtlo = 0;
    chk("mtboth", {hi, lo}, {32'h0F0F0F0F, 32'h0F0F0F0F});

    // reset in the fifth DIV_RUN cycle
    start_div = 1;
    tick();
    start_div = 0;
    tick(); tick(); tick(); tick();
    chk("abort_pre", div_ctrl, 1);
    reset = 1; div_done = 1;
    tick();
    reset = 0; div_done = 0;
    chk("abort_ctrl", div_ctrl, 0);
    chk("abort_hilo", {hi, lo}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", op_done, 0);
    tick();
    chk("abort_done2", op_done, 0);
    chk("sb_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, 16, width of the saturating busy-cycle counter.
REQ-002 Parameter DIV0_WRITES_HILO, 0, 1 = HI/LO take divider outputs on divide-by-zero; 0 = HI/LO unchanged.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 start_div / start_mult  in  1 each  one-cycle operation requests from the control unit.
REQ-006 mthi / mtlo  in  1 each  direct-write strobes; wr_data  in  32  write value.
REQ-007 div_ctrl  out  1  level request to divider; div_done, div0  in  1; div_hi, div_lo  in  32.
REQ-008 mult_ctrl  out  1  level request to multiplier; mult_done  in  1; mult_hi, mult_lo  in  32.
REQ-009 hi, lo  out  32 each  architectural HI/LO registers.
REQ-010 busy  out  1; op_done  out  1 pulse; div0_exc  out  1 pulse; start_conflict  out  1 pulse.
REQ-011 busy_cycles  out  CNT_WIDTH  cycles spent in the last or current operation.

Function
REQ-012 FSM states: IDLE, DIV_RUN, MULT_RUN, CAPTURE; all outputs registered.
REQ-013 IDLE: start_div -> DIV_RUN next cycle; else start_mult -> MULT_RUN; div wins if both asserted.
REQ-014 Simultaneous start_div and start_mult -> start_conflict pulses 1 cycle, multiply request discarded.
REQ-015 div_ctrl = 1 exactly while in DIV_RUN; mult_ctrl = 1 exactly while in MULT_RUN; never both.
REQ-016 done inputs ignored in the first cycle of a RUN state (stale-done guard; divider reports at earliest one cycle after ctrl rises).
REQ-017 DIV_RUN, div_done=1 (second RUN cycle or later): latch div_hi/div_lo and div0 into holding regs, -> CAPTURE.
REQ-018 MULT_RUN, mult_done=1 (second RUN cycle or later): latch mult_hi/mult_lo, -> CAPTURE.
REQ-019 CAPTURE (1 cycle): hi/lo written from holding regs, op_done=1, ctrl lines 0, -> IDLE.
REQ-020 Divide with div0=1: div0_exc=1 in CAPTURE cycle; hi/lo written only if DIV0_WRITES_HILO=1; op_done still pulses.
REQ-021 busy = 1 in DIV_RUN, MULT_RUN, CAPTURE; 0 in IDLE.
REQ-022 start_div/start_mult while busy ignored, no conflict pulse, no queuing.
REQ-023 mthi/mtlo in IDLE: hi/lo <= wr_data next edge; both set -> both written.
REQ-024 mthi/mtlo while busy ignored; mthi/mtlo with start in same IDLE cycle -> write performed and operation started; CAPTURE later overwrites.
REQ-025 busy_cycles cleared to 0 on entering a RUN state, +1 per cycle in RUN/CAPTURE, saturates at all-ones, held in IDLE.
REQ-026 No timeout; a RUN state persists until its done input (long divides up to 2^31 cycles legal).
REQ-027 A new operation may start in the IDLE cycle directly after CAPTURE.

Reset
REQ-028 reset=1 at a clock edge: state IDLE, hi=lo=0, holding regs 0, busy_cycles=0, all ctrl and pulse outputs 0.
REQ-029 Reset mid-operation aborts it: ctrl drops next edge, no op_done, no HI/LO update; reset dominates all other inputs.

Verification
REQ-030 start_div, div returns hi=0x00000001, lo=0xFFFFFFFE (7 / -3) -> hi=0x00000001, lo=0xFFFFFFFE after CAPTURE, op_done one pulse, div_ctrl low afterwards.
REQ-031 start_div, div_done=1 and div0=1 in second RUN cycle, DIV0_WRITES_HILO=0, hi=0xAAAA0000 beforehand -> div0_exc pulse, hi stays 0xAAAA0000, busy_cycles=3.
REQ-032 start_div and start_mult same cycle -> start_conflict pulse, only div_ctrl rises, mult_ctrl stays 0.
REQ-033 mthi with wr_data=0x12345678 in IDLE -> hi=0x12345678, lo unchanged; mtlo during MULT_RUN -> lo unchanged.
REQ-034 reset asserted in 5th cycle of DIV_RUN -> next edge div_ctrl=0, hi=lo=0, busy=0, no op_done.
REQ-035 div_done held high from previous op when new start_div arrives -> not captured in first RUN cycle; capture only on later done.
